// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory port: access sizes,
// responder FSM states and the latched request record.
package riscv_mem_pkg;

  // Access size codes taken from funct3[1:0]; 2'b11 is not a legal size.
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: builds the store strobe and
// replicated write word, extracts and extends load data, and flags misalignment.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] raw_word_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  strobe_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shiftedWord;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign shiftedWord = raw_word_i >> {addr_i, 3'b000};
  assign loadByte    = shiftedWord[7:0];
  assign loadHalf    = addr_i[1] ? raw_word_i[31:16] : raw_word_i[15:0];

  // Decode size into lane strobes, replicate store data across lanes and extend the selected load lane.
  always_comb begin
    strobe_o   = 4'b0000;
    wword_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    case (size_i)
      MEM_SIZE_B: begin
        strobe_o = 4'b0001 << addr_i;
        wword_o  = {4{wdata_i[7:0]}};
        rdata_o  = unsigned_i ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
      end
      MEM_SIZE_H: begin
        misalign_o = addr_i[0];
        strobe_o   = addr_i[1] ? 4'b1100 : 4'b0011;
        wword_o    = {2{wdata_i[15:0]}};
        rdata_o    = unsigned_i ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
      end
      MEM_SIZE_W: begin
        misalign_o = (addr_i != 2'b00);
        strobe_o   = 4'b1111;
        wword_o    = wdata_i;
        rdata_o    = raw_word_i;
      end
      default: begin
        strobe_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage port: one request at a time,
// configurable wait states, commit on the edge entering RESP, one-cycle response.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  mem_req_t          req_q;
  logic              ready_q;
  logic              busy_q;
  logic              respValid_q;
  logic [31:0]       respRdata_q;
  logic              respErr_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  mem_req_t          inReq;
  mem_req_t          curReq;
  logic              accept;
  logic              enterResp;
  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       rawWord;
  logic [3:0]        strobe;
  logic [31:0]       wword;
  logic [31:0]       loadData;
  logic              misalign;
  logic              reqErr;
  logic              commitWrite;
  logic [31:0]       respRdata_d;

  assign inReq = '{we: req_we, size: req_size, isUnsigned: req_unsigned,
                   addr: req_addr, wdata: req_wdata};

  assign accept    = req_valid && ready_q;
  assign enterResp = ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_BUSY) && (cnt_q == LAST_CNT));

  // With zero wait states the commit happens on the accept edge, so it must see the live request.
  assign curReq  = (state_q == S_IDLE) ? inReq : req_q;
  assign wordIdx = curReq.addr[ADDR_W+1:2];
  assign rawWord = mem_q[wordIdx];

  mem_lane_align u_align (
    .addr_i     (curReq.addr[1:0]),
    .size_i     (curReq.size),
    .unsigned_i (curReq.isUnsigned),
    .raw_word_i (rawWord),
    .wdata_i    (curReq.wdata),
    .strobe_o   (strobe),
    .wword_o    (wword),
    .rdata_o    (loadData),
    .misalign_o (misalign)
  );

  assign reqErr      = (curReq.size == 2'b11) || misalign || (curReq.addr >= ADDR_LIMIT);
  assign commitWrite = enterResp && curReq.we && !reqErr && !reset;
  assign respRdata_d = (curReq.we || reqErr) ? 32'h0 : loadData;

  // RAM write port: only strobed lanes of a legal store change, on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (commitWrite) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (strobe[lane]) begin
          mem_q[wordIdx][8*lane +: 8] <= wword[8*lane +: 8];
        end
      end
    end
  end

  // Responder FSM with request latch, wait counter and registered handshake/response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      respValid_q <= 1'b0;
      respRdata_q <= 32'h0;
      respErr_q   <= 1'b0;
    end else begin
      respValid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_q   <= inReq;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q     <= S_RESP;
              respValid_q <= 1'b1;
              respRdata_q <= respRdata_d;
              respErr_q   <= reqErr;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q == LAST_CNT) begin
            state_q     <= S_RESP;
            respValid_q <= 1'b1;
            respRdata_q <= respRdata_d;
            respErr_q   <= reqErr;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign resp_valid = respValid_q;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

endmodule
